// File: rtl/toggle_bank_pkg.sv
// Shared types and helpers for the toggle bank: operating-mode encoding and
// an all-ones constant generator for arbitrary widths.
package toggle_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  function automatic logic [63:0] all_ones(input int width);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < width) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/toggle_bank_tff_cell.sv
// Single edge-triggered T flip-flop: async reset, then sync clear, sync load
// and toggle, in that priority.
module tff_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic load_val,
  input  logic tgl,
  output logic q
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)       q_d = RST_VAL;
    else if (load) q_d = load_val;
    else if (tgl)  q_d = ~q_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= RST_VAL;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/toggle_bank.sv
// WIDTH-bit bank of T flip-flops usable as independent toggles or as a
// synchronous up/down counter with optional saturation.
module toggle_bank
  import toggle_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter bit               WRAP    = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] ONES = WIDTH'(all_ones(WIDTH));

  mode_e            mode_s;
  logic [WIDTH-1:0] up_c, dn_b, tgl;
  logic             at_max, at_min;
  logic             wrap_q, wrap_d, sat_q, sat_d;

  assign mode_s = mode_e'(mode);
  assign at_max = (q == ONES);
  assign at_min = (q == '0);

  // Bit i toggles on count when every lower bit is 1 (up) or 0 (down).
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    if (i == 0) begin : g_lsb
      assign up_c[i] = 1'b1;
      assign dn_b[i] = 1'b1;
    end else begin : g_upper
      assign up_c[i] = &q[i-1:0];
      assign dn_b[i] = ~|q[i-1:0];
    end
  end

  always_comb begin
    tgl    = '0;
    wrap_d = 1'b0;
    sat_d  = sat_q;
    if (clr || load) begin
      sat_d = 1'b0;
    end else if (en) begin
      case (mode_s)
        MODE_TOGGLE: begin
          tgl   = t;
          sat_d = 1'b0;
        end
        MODE_UP: begin
          if (at_max && !WRAP) begin
            sat_d = 1'b1;
          end else begin
            tgl    = up_c;
            sat_d  = 1'b0;
            wrap_d = at_max;
          end
        end
        MODE_DOWN: begin
          if (at_min && !WRAP) begin
            sat_d = 1'b1;
          end else begin
            tgl    = dn_b;
            sat_d  = 1'b0;
            wrap_d = at_min;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell #(.RST_VAL(RST_VAL[i])) u_cell (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .load     (load),
      .load_val (load_val[i]),
      .tgl      (tgl[i]),
      .q        (q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign wrap = wrap_q;
  assign sat  = sat_q;

endmodule

// File: tb/tb_toggle_bank.sv
// Bench for toggle_bank: a wrapping and a saturating instance share stimulus;
// a reference model queues expected state per edge, compared after each edge.
module tb_toggle_bank;

  localparam int         W  = 4;
  localparam logic [3:0] RV = 4'h5;

  logic       clk = 1'b0;
  logic       rst, en, clr, load;
  logic [1:0] mode;
  logic [3:0] t, load_val;
  logic [3:0] q_w, q_s;
  logic       wrap_w, wrap_s, sat_w, sat_s;

  always #5 clk = ~clk;

  toggle_bank #(.WIDTH(W), .WRAP(1'b1), .RST_VAL(RV)) dut_w (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .clr(clr),
    .load(load), .load_val(load_val), .q(q_w), .wrap(wrap_w), .sat(sat_w)
  );

  toggle_bank #(.WIDTH(W), .WRAP(1'b0), .RST_VAL(RV)) dut_s (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .clr(clr),
    .load(load), .load_val(load_val), .q(q_s), .wrap(wrap_s), .sat(sat_s)
  );

  typedef struct {
    logic [3:0] qw; logic ww; logic sw;
    logic [3:0] qs; logic ws; logic ss;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mq[2];
  logic       mwr[2];
  logic       msat[2];
  int         total = 0;
  int         bad   = 0;
  int         wrap_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k] = RV; mwr[k] = 1'b0; msat[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input int k, input bit wrapm);
    logic [3:0] cq;
    cq = mq[k];
    mwr[k] = 1'b0;
    if (clr) begin
      mq[k] = RV; msat[k] = 1'b0;
    end else if (load) begin
      mq[k] = load_val; msat[k] = 1'b0;
    end else if (en) begin
      case (mode)
        2'b00: begin mq[k] = cq ^ t; msat[k] = 1'b0; end
        2'b01: begin
          if (cq == 4'hF && !wrapm) msat[k] = 1'b1;
          else begin
            mq[k] = cq + 4'd1; msat[k] = 1'b0; mwr[k] = (cq == 4'hF);
          end
        end
        2'b10: begin
          if (cq == 4'h0 && !wrapm) msat[k] = 1'b1;
          else begin
            mq[k] = cq - 4'd1; msat[k] = 1'b0; mwr[k] = (cq == 4'h0);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step();
    exp_t e, o;
    model_edge(0, 1'b1);
    model_edge(1, 1'b0);
    e.qw = mq[0]; e.ww = mwr[0]; e.sw = msat[0];
    e.qs = mq[1]; e.ws = mwr[1]; e.ss = msat[1];
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk("sb_q_w",    32'(q_w),    32'(o.qw));
    chk("sb_wrap_w", 32'(wrap_w), 32'(o.ww));
    chk("sb_sat_w",  32'(sat_w),  32'(o.sw));
    chk("sb_q_s",    32'(q_s),    32'(o.qs));
    chk("sb_wrap_s", 32'(wrap_s), 32'(o.ws));
    chk("sb_sat_s",  32'(sat_s),  32'(o.ss));
  endtask

  task automatic do_load(input logic [3:0] v);
    clr = 1'b0; load = 1'b1; load_val = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0;
    mode = 2'b00; t = '0; load_val = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_q",    32'(q_w),    32'(RV));
    chk("rst_wrap", 32'(wrap_w), 32'd0);
    chk("rst_sat",  32'(sat_s),  32'd0);

    // toggle
    do_load(4'h0);
    en = 1'b1; mode = 2'b00; t = 4'b1010;
    step(); chk("tog_1", 32'(q_w), 32'hA);
    step(); chk("tog_2", 32'(q_w), 32'h0);
    en = 1'b0; t = 4'b1111;
    step(); chk("tog_off", 32'(q_w), 32'h0);

    // up wrap / up saturate
    do_load(4'hE);
    en = 1'b1; mode = 2'b01;
    step(); chk("up_f", 32'(q_w), 32'hF);
    step(); chk("up_wrap_q", 32'(q_w), 32'h0); chk("up_wrap_p", 32'(wrap_w), 32'd1);
    chk("up_sat_s", 32'(sat_s), 32'd1);
    step(); chk("up_1", 32'(q_w), 32'h1); chk("up_wrap_end", 32'(wrap_w), 32'd0);

    // down saturate
    do_load(4'h1);
    mode = 2'b10;
    step(); chk("dn_0a", 32'(q_s), 32'h0); chk("dn_sat_a", 32'(sat_s), 32'd0);
    step(); chk("dn_0b", 32'(q_s), 32'h0); chk("dn_sat_b", 32'(sat_s), 32'd1);
    step(); chk("dn_0c", 32'(q_s), 32'h0); chk("dn_nowrap", 32'(wrap_s), 32'd0);
    do_load(4'h3);
    chk("dn_ld_q", 32'(q_s), 32'h3); chk("dn_ld_sat", 32'(sat_s), 32'd0);

    // priority
    clr = 1'b1; load = 1'b1; load_val = 4'h9; en = 1'b1; mode = 2'b01;
    step(); chk("pri_clr", 32'(q_w), 32'(RV));
    clr = 1'b0;
    step(); chk("pri_load", 32'(q_w), 32'h9);
    load = 1'b0; mode = 2'b11;
    repeat (5) step();
    chk("pri_hold", 32'(q_w), 32'h9);

    // mode switch
    do_load(4'h0);
    mode = 2'b01;
    repeat (3) step();
    chk("sw_up3", 32'(q_w), 32'h3);
    mode = 2'b10;
    step(); chk("sw_dn2", 32'(q_w), 32'h2);
    step(); chk("sw_dn1", 32'(q_w), 32'h1);

    // one wrap pulse per 16 UP edges
    do_load(4'h0);
    mode = 2'b01; wrap_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (wrap_w) wrap_cnt++;
    end
    chk("wrap_count", 32'(wrap_cnt), 32'd1);

    // asynchronous reset mid-cycle with sat set
    do_load(4'h0);
    mode = 2'b10;
    step();
    step();
    chk("pre_rst_sat", 32'(sat_s), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_q_w",  32'(q_w),    32'(RV));
    chk("arst_q_s",  32'(q_s),    32'(RV));
    chk("arst_sat",  32'(sat_s),  32'd0);
    chk("arst_wrap", 32'(wrap_w), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    mode = 2'b11;
    step();

    // random mix
    for (int i = 0; i < 200; i++) begin
      en       = ($urandom_range(0, 5) != 0);
      mode     = 2'($urandom_range(0, 3));
      t        = 4'($urandom_range(0, 15));
      clr      = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom_range(0, 15));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/toggle_bank.md
# toggle_bank

Parametrised, clocked bank of T flip-flops that extends the single-bit toggle latch into a WIDTH-bit register. It runs as independent per-bit toggles or as a chained synchronous up/down counter, with optional saturation. It sits between control logic and datapath wherever divided clocks-as-enables, toggle flags or small event counters are needed. All state is edge-triggered, so it avoids the combinational feedback that a level-sensitive toggle latch creates.

## Interface
- WIDTH, 8, number of T flip-flop channels / counter width (≥2)
- WRAP, 1, 1 = counter wraps modulo 2^WIDTH; 0 = counter saturates at all-ones (up) or zero (down)
- RST_VAL, 0, value loaded into q on reset and on clr

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  global enable; no state change when 0, except via clr and load
- mode  in  2  operation select: 00 TOGGLE, 01 UP, 10 DOWN, 11 HOLD
- t  in  WIDTH  per-bit toggle request; used in TOGGLE mode only
- clr  in  1  synchronous clear to RST_VAL
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  value taken on load
- q  out  WIDTH  register state
- wrap  out  1  registered one-cycle pulse on a counter wrap (UP: all-ones→0; DOWN: 0→all-ones)
- sat  out  1  registered level; 1 while WRAP=0 and the counter is pinned at its limit in the current count direction

## Operation
- Priority on each rising edge: rst (async) > clr > load > en.
- TOGGLE (00) with en=1: q[i] ← q[i] ^ t[i] for every i. wrap=0. sat=0.
- UP (01) with en=1: bit i toggles when all lower bits are 1, so q ← q+1.
  - At q = all-ones with WRAP=1: q ← 0, wrap=1 for one cycle.
  - At q = all-ones with WRAP=0: q holds, sat=1, wrap=0.
- DOWN (10) with en=1: bit i toggles when all lower bits are 0, so q ← q−1.
  - At q = 0 with WRAP=1: q ← all-ones, wrap=1.
  - At q = 0 with WRAP=0: q holds, sat=1.
- HOLD (11), or en=0: q holds. wrap=0. sat keeps its value.
- clr: q ← RST_VAL. wrap=0. sat=0. Ignores en and mode.
- load: q ← load_val. wrap=0. sat=0. Ignores en and mode.
- sat is recomputed on every enabled UP/DOWN edge and cleared by any other enabled-mode edge.
- Changing mode takes effect on the next edge. No state is retained across a mode change except q.
- Arithmetic is unsigned modulo 2^WIDTH. No carry-out port beyond wrap.

## Timing
- Reset values: q = RST_VAL, wrap = 0, sat = 0, applied asynchronously while rst=1.
- Deassertion of rst is synchronised by the caller. The first operative edge is the first rising clk with rst=0.
- Latency: q, wrap and sat update on the same rising edge. There is no combinational path from inputs to outputs.
- wrap is high for exactly one cycle, coincident with the wrapped value of q.
- Consecutive enabled UP edges produce wrap every 2^WIDTH cycles.
- clr and load asserted together: clr wins.
- rst asserted mid-count forces the reset state immediately, without waiting for clk.

## Structure
- Package toggle_pkg holds the mode typedef (TOGGLE=2'b00, UP=2'b01, DOWN=2'b10, HOLD=2'b11) and a helper that computes the all-ones value for a given width.
- Sub-module tff_cell: one T flip-flop with async rst, sync clr/load, toggle input and reset value. toggle_bank instantiates WIDTH cells via generate and builds the per-bit toggle enables: t[i] in TOGGLE mode, carry/borrow chain in UP/DOWN mode, gated by en and saturation.
- wrap and sat registers live in toggle_bank.

## Test plan
- Reset: WIDTH=4, RST_VAL=4'h5; assert rst mid-cycle → q=5, wrap=0, sat=0 immediately, before the next edge.
- TOGGLE: q=0, en=1, t=4'b1010 for 2 edges → q=4'b1010, then 4'b0000. With en=0, t=4'b1111 → q unchanged.
- UP wrap: WRAP=1, load 4'hE, then UP for 3 edges → q=F, 0 with wrap=1 for that cycle only, then 1 with wrap=0.
- DOWN saturate: WRAP=0, load 4'h1, then DOWN for 3 edges → q=0, 0, 0 with sat=1 from the second edge and wrap never asserted. A following load 4'h3 → q=3, sat=0.
- Priority: clr=1, load=1, load_val=4'h9, en=1, mode=UP → q=RST_VAL. Then load only → q=9. Then mode=HOLD, en=1 for 5 edges → q=9.
- Mode switch: count UP from 0 to 3, switch to DOWN on the next edge → q=2, then 1. Wrap coverage over a full 16-cycle UP run gives exactly one wrap pulse.
